// File: rtl/coax_rx_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coax_rx_buffer_if : coax_rx capture side and host read side bundle       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface coax_rx_buffer_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic [9:0]  rx_data;
  logic        rx_data_available;
  logic        rx_error;
  logic        rx_read;
  logic        read;
  logic [9:0]  data;
  logic        data_error;
  logic        data_available;
  logic        full;
  logic [AW:0] level;

  modport slave (
    input  rx_data, rx_data_available, rx_error, read,
    output rx_read, data, data_error, data_available, full, level
  );

  modport master (
    output rx_data, rx_data_available, rx_error, read,
    input  rx_read, data, data_error, data_available, full, level
  );
endinterface
`default_nettype wire

// File: rtl/coax_rx_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coax_rx_buffer : FWFT FIFO draining coax_rx words and in-band error marks |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module coax_rx_buffer #(
  parameter int DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  coax_rx_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [0:0]  c_IDLE = 1'b0;
  localparam logic [0:0]  c_WAIT = 1'b1;

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic          r_err_pending;
  logic          r_error_q;
  logic          r_read_q;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push_ok;
  logic w_wr_err;
  logic w_wr_data;
  logic w_push;
  logic w_err_rise;

  assign w_full     = (r_level == c_FULL_LEVEL);
  assign w_empty    = (r_level == '0);
  assign w_pop      = bus.read & ~r_read_q & ~w_empty;
  assign w_push_ok  = ~w_full | w_pop;
  assign w_err_rise = bus.rx_error & ~r_error_q;
  assign w_push     = w_wr_err | w_wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (w_wr_data) w_next_state = c_WAIT;
      c_WAIT: if (!bus.rx_data_available) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Error markers win over data; the reset term keeps rx_read low while held in reset.
  always_comb begin
    w_wr_err  = 1'b0;
    w_wr_data = 1'b0;
    if (r_state == c_IDLE && reset) begin
      if (r_err_pending) begin
        w_wr_err  = w_push_ok;
      end else begin
        w_wr_data = bus.rx_data_available & w_push_ok;
      end
    end
    bus.rx_read = w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_err ? {1'b1, 10'b0} : {1'b0, bus.rx_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_err_pending <= 1'b0;
      r_error_q     <= 1'b0;
      r_read_q      <= 1'b0;
    end else begin
      r_error_q <= bus.rx_error;
      r_read_q  <= bus.read;
      // A fresh edge landing in the cycle the old marker is written stays pending.
      r_err_pending <= w_err_rise | (r_err_pending & ~w_wr_err);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.data           = w_empty ? 10'b0 : r_mem[r_rd_ptr][9:0];
  assign bus.data_error     = w_empty ? 1'b0  : r_mem[r_rd_ptr][10];
  assign bus.data_available = ~w_empty;
  assign bus.full           = w_full;
  assign bus.level          = r_level;
endmodule
`default_nettype wire
